apb_slave_regfile: RTL and testbench

APB3 completer that terminates transfers from the APB master and serves a small word-addressed register bank. It inserts a fixed, parameterised number of wait states, flags out-of-range, misaligned and illegal writes on PSLVERR, and drives register 1 out as a control word for downstream logic. It is the peripheral-side endpoint used to exercise and validate the master on the FPGA.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_regbank.sv | 46 ++++
 rtl/apb_slave_regfile.sv | 143 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, register indices and default ID.
// Imported by both the completer and the master side of the link.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  localparam int REG_ID   = 0;
  localparam int REG_CTRL = 1;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regbank.sv
// Word register storage: reg 0 is a constant ID, the rest are read/write.
// One indexed write port, one combinational read port, plus a tap on the
// control register for downstream logic.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
  localparam int         IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  output logic [31:0]      o_ctrl
);

  logic [31:0] w_regs [NUM_REGS];

  assign w_regs[REG_ID] = ID_VALUE;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] r_q;

      // Each RW register loads when the write port targets its index.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q <= '0;
        end else if (i_we && (i_wr_idx == IDX_W'(gi))) begin
          r_q <= i_wr_data;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  assign o_rd_data = w_regs[i_rd_idx];
  assign o_ctrl    = w_regs[REG_CTRL];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with fixed wait states in front of a small register bank.
// Errors (out of range, misaligned, write to ID) are answered on PSLVERR;
// protocol violations by the master set a sticky flag.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        PCLK,
  input  logic        PRESET_n,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] ctrl_o,
  output logic        proto_err_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_state_e  r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, r_wdata;
  logic        r_write;
  logic        r_pready, r_pslverr, r_proto_err;
  logic [31:0] r_prdata;

  logic             w_latch, w_enter_done, w_proto_set, w_we;
  logic [31:0]      w_req_addr;
  logic             w_req_write, w_req_err;
  logic [IDX_W-1:0] w_req_idx;
  logic [31:0]      w_rd_data;

  // With zero wait states DONE is entered on the setup edge itself, before
  // the request is latched, so the live bus is used only while in IDLE.
  assign w_req_addr  = (r_state == ST_IDLE) ? PADDR  : r_addr;
  assign w_req_write = (r_state == ST_IDLE) ? PWRITE : r_write;
  assign w_req_idx   = w_req_addr[IDX_W+1:2];
  assign w_req_err   = (|w_req_addr[31:IDX_W+2]) |
                       (|w_req_addr[1:0]) |
                       (w_req_write && (w_req_idx == IDX_W'(REG_ID)));

  // Commit only a clean, still-selected write; r_pslverr holds this
  // transfer's error decode during DONE.
  assign w_we = (r_state == ST_DONE) & PSEL & PENABLE & r_write & ~r_pslverr;

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .i_clk     (PCLK),
    .i_rst_n   (PRESET_n),
    .i_we      (w_we),
    .i_wr_idx  (r_addr[IDX_W+1:2]),
    .i_wr_data (r_wdata),
    .i_rd_idx  (w_req_idx),
    .o_rd_data (w_rd_data),
    .o_ctrl    (ctrl_o)
  );

  // Next-state, wait counter and protocol-violation decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_enter_done = 1'b0;
    w_proto_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_latch    = 1'b1;
          w_cnt_next = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_next = ST_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
          end
        end else if (PSEL && PENABLE) begin
          w_proto_set = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!(PSEL && PENABLE)) begin
          w_proto_set  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_next = ST_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        // PREADY is already registered high here; an abort only drops the write.
        if (!(PSEL && PENABLE)) begin
          w_proto_set = 1'b1;
        end
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, latched request and registered response outputs.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end
      r_pready    <= w_enter_done;
      r_pslverr   <= w_enter_done & w_req_err;
      r_prdata    <= (w_enter_done && !w_req_write && !w_req_err) ? w_rd_data : '0;
      r_proto_err <= r_proto_err | w_proto_set;
    end
  end

  assign PREADY      = r_pready;
  assign PSLVERR     = r_pslverr;
  assign PRDATA      = r_prdata;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: one instance with two wait
// states, one with none. Expected responses are queued before each transfer
// and popped when the completer answers.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        use0 = 1'b0;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, perr_a, perr_b;
  logic [31:0] prdata, ctrl;
  logic        pready, pslverr, perr;

  assign psel_a  = psel & ~use0;
  assign psel_b  = psel & use0;
  assign prdata  = use0 ? prdata_b  : prdata_a;
  assign ctrl    = use0 ? ctrl_b    : ctrl_a;
  assign pready  = use0 ? pready_b  : pready_a;
  assign pslverr = use0 ? pslverr_b : pslverr_a;
  assign perr    = use0 ? perr_b    : perr_a;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(2), .ID_VALUE(32'hA5B0_0001)) dut (
    .PCLK(clk), .PRESET_n(rst_n), .PSEL(psel_a), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .ctrl_o(ctrl_a), .proto_err_o(perr_a)
  );

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) dut0 (
    .PCLK(clk), .PRESET_n(rst_n), .PSEL(psel_b), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .ctrl_o(ctrl_b), .proto_err_o(perr_b)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // One APB transfer. During the access phase the address, data and
  // direction lines are scrambled: the completer must use the setup values.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic [31:0] ctrl_at_ready, output logic pready_after);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = addr ^ 32'h0000_0004;
    pwdata  = ~wd;
    pwrite  = ~wr;
    lat = 1;
    while (pready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prdata; err = pslverr; ctrl_at_ready = ctrl;
    @(posedge clk); #1;
    pready_after = pready;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("xfer dut%0d %s addr=%h wdata=%h rdata=%h err=%b lat=%0d",
             use0 ? 0 : 2, wr ? "WR" : "RD", addr, wd, rd, err, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({pready_a, pslverr_a, perr_a, prdata_a, ctrl_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got rdy=%b err=%b perr=%b rdata=%h ctrl=%h required all 0",
               pready_a, pslverr_a, perr_a, prdata_a, ctrl_a);
    end
    n_checks++;
    if ({pready_b, pslverr_b, perr_b, prdata_b, ctrl_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: got rdy=%b err=%b perr=%b rdata=%h ctrl=%h required all 0",
               pready_b, pslverr_b, perr_b, prdata_b, ctrl_b);
    end
  endtask

  task automatic test_read_id();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex;
    exp_q.push_back('{32'hA5B0_0001, 1'b0});
    apb_xfer(32'h0, 1'b0, 32'h0, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if (rd !== ex.data) begin n_fail++; $display("FAIL id_rdata: got %h required %h", rd, ex.data); end
    n_checks++;
    if (err !== ex.err) begin n_fail++; $display("FAIL id_pslverr: got %b required %b", err, ex.err); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL id_latency: got %0d required 3", lat); end
    n_checks++;
    if (pa !== 1'b0) begin n_fail++; $display("FAIL id_pready_width: got %b after DONE required 0", pa); end
  endtask

  task automatic test_write_ctrl();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex;
    exp_q.push_back('{32'h0, 1'b0});
    apb_xfer(32'h4, 1'b1, 32'hDEAD_BEEF, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if ({rd, err} !== {ex.data, ex.err}) begin
      n_fail++; $display("FAIL wr_resp: got rdata=%h err=%b required %h/%b", rd, err, ex.data, ex.err);
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d required 3", lat); end
    n_checks++;
    if (cr !== 32'h0) begin n_fail++; $display("FAIL ctrl_during_ready: got %h required 0", cr); end
    n_checks++;
    if (ctrl !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ctrl_after_write: got %h required deadbeef", ctrl); end
    exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
    apb_xfer(32'h4, 1'b0, 32'h0, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if ({rd, err} !== {ex.data, ex.err}) begin
      n_fail++; $display("FAIL rd_reg1: got rdata=%h err=%b required %h/%b", rd, err, ex.data, ex.err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex;
    logic [31:0] wr_addrs [3] = '{32'h00, 32'h40, 32'h06};
    logic [31:0] rd_addrs [4] = '{32'h40, 32'h00, 32'h04, 32'h05};
    exp_t        rd_exp   [4] = '{'{32'h0, 1'b1}, '{32'hA5B0_0001, 1'b0},
                                  '{32'hDEAD_BEEF, 1'b0}, '{32'h0, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'h0, 1'b1});
      apb_xfer(wr_addrs[i], 1'b1, 32'h1234_5678, rd, err, lat, cr, pa);
      ex = exp_q.pop_front();
      n_checks++;
      if ({rd, err} !== {ex.data, ex.err} || lat !== 3) begin
        n_fail++;
        $display("FAIL err_write_%h: got rdata=%h err=%b lat=%0d required %h/%b lat=3",
                 wr_addrs[i], rd, err, lat, ex.data, ex.err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rd_exp[i]);
      apb_xfer(rd_addrs[i], 1'b0, 32'h0, rd, err, lat, cr, pa);
      ex = exp_q.pop_front();
      n_checks++;
      if ({rd, err} !== {ex.data, ex.err}) begin
        n_fail++;
        $display("FAIL err_read_%h: got rdata=%h err=%b required %h/%b", rd_addrs[i], rd, err, ex.data, ex.err);
      end
    end
    n_checks++;
    if (ctrl !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ctrl_unchanged: got %h required deadbeef", ctrl); end
    n_checks++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL no_proto_err: got %b required 0", perr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex;
    logic [31:0] addrs [3] = '{32'h08, 32'h08, 32'h00};
    logic        wrs   [3] = '{1'b1, 1'b0, 1'b0};
    use0 = 1'b1;
    exp_q.push_back('{32'h0, 1'b0});
    exp_q.push_back('{32'hCAFE_0008, 1'b0});
    exp_q.push_back('{32'hA5B0_0001, 1'b0});
    for (int i = 0; i < 3; i++) begin
      apb_xfer(addrs[i], wrs[i], 32'hCAFE_0008, rd, err, lat, cr, pa);
      ex = exp_q.pop_front();
      n_checks++;
      if ({rd, err} !== {ex.data, ex.err} || lat !== 1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got rdata=%h err=%b lat=%0d required %h/%b lat=1",
                 i, rd, err, lat, ex.data, ex.err);
      end
    end
    use0 = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex; logic seen;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pready === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    penable = 1'b0; pwrite = 1'b0;
    $display("xfer dut2 WR addr=0000000c aborted in WAIT pready_seen=%b perr=%b", seen, perr);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b required 0", seen); end
    n_checks++;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL abort_proto_err: got %b required 1", perr); end
    exp_q.push_back('{32'h0, 1'b0});
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if ({rd, err} !== {ex.data, ex.err}) begin
      n_fail++; $display("FAIL abort_reg3: got rdata=%h err=%b required %h/%b", rd, err, ex.data, ex.err);
    end
    n_checks++;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL proto_err_sticky: got %b required 1", perr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL proto_err_reset: got %b required 0", perr); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, cr; logic err, pa; int lat; exp_t ex;
    exp_q.push_back('{32'h0, 1'b0});
    apb_xfer(32'h4, 1'b1, 32'h1111_0001, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if (ctrl !== 32'h1111_0001 || {rd, err} !== {ex.data, ex.err}) begin
      n_fail++; $display("FAIL pre_reset_write: got ctrl=%h rdata=%h err=%b required 11110001 %h/%b",
                         ctrl, rd, err, ex.data, ex.err);
    end
    psel = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pready_a, pslverr_a, perr_a, prdata_a, ctrl_a} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b err=%b perr=%b rdata=%h ctrl=%h required all 0",
               pready_a, pslverr_a, perr_a, prdata_a, ctrl_a);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ctrl !== 32'h0) begin n_fail++; $display("FAIL ctrl_after_reset: got %h required 0", ctrl); end
    exp_q.push_back('{32'h0, 1'b0});
    apb_xfer(32'h4, 1'b0, 32'h0, rd, err, lat, cr, pa);
    ex = exp_q.pop_front();
    n_checks++;
    if ({rd, err} !== {ex.data, ex.err}) begin
      n_fail++; $display("FAIL reg1_after_reset: got rdata=%h err=%b required %h/%b", rd, err, ex.data, ex.err);
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_ctrl();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
